// File: rtl/vec_issue_seq_if.sv
// Control/status bundle between the vector issue sequencer and its requester.
// The master side requests operations; the slave side is the sequencer.
interface vec_issue_seq_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic             abort;
    logic             en;
    logic [IDX_W-1:0] idx;
    logic             issue_valid;
    logic             last;
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic             busy;
    logic             done;

    modport master (
        output start, abort,
        input  en, idx, issue_valid, last, res_valid, res_idx, busy, done
    );

    modport slave (
        input  start, abort,
        output en, idx, issue_valid, last, res_valid, res_idx, busy, done
    );
endinterface

// File: rtl/vec_issue_seq.sv
// Issue sequencer for one operation of the 8x8 pipelined vector multiplier:
// issues VEC_LEN indices, tracks them through a PIPE_LAT-deep pipe, pulses done.
module vec_issue_seq #(
    parameter int IDX_W    = 4,
    parameter int VEC_LEN  = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic           clk,
    input  logic           rstn,
    vec_issue_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VEC_LEN - 1);
    localparam logic [3:0]       DRAIN_END = 4'(PIPE_LAT - 1);

    state_t           state;
    logic             en_r;
    logic             iv_r;
    logic             last_r;
    logic             busy_r;
    logic             done_r;
    logic [IDX_W-1:0] idx_r;
    logic [3:0]       dcnt;
    // Each stage holds {valid, index}; idle stages carry an all-ones index.
    logic [IDX_W:0]   dl [PIPE_LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            en_r   <= 1'b0;
            iv_r   <= 1'b0;
            last_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            idx_r  <= '1;
            dcnt   <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) dl[i] <= {1'b0, {IDX_W{1'b1}}};
        end else if (bus.abort) begin
            state  <= S_IDLE;
            en_r   <= 1'b0;
            iv_r   <= 1'b0;
            last_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            idx_r  <= '1;
            dcnt   <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) dl[i] <= {1'b0, {IDX_W{1'b1}}};
        end else begin
            dl[0] <= {iv_r, idx_r};
            for (int unsigned i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_ISSUE;
                        en_r   <= 1'b1;
                        iv_r   <= 1'b1;
                        busy_r <= 1'b1;
                        idx_r  <= '0;
                        last_r <= (LAST_IDX == '0);
                    end
                end
                S_ISSUE: begin
                    if (last_r) begin
                        state  <= S_DRAIN;
                        en_r   <= 1'b0;
                        iv_r   <= 1'b0;
                        last_r <= 1'b0;
                        idx_r  <= '1;
                        dcnt   <= DRAIN_END;
                    end else begin
                        idx_r  <= idx_r + 1'b1;
                        last_r <= ((idx_r + 1'b1) == LAST_IDX);
                    end
                end
                S_DRAIN: begin
                    // The final result leaves the pipe in the last drain cycle.
                    if (dcnt == '0) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.en          = en_r;
    assign bus.idx         = idx_r;
    assign bus.issue_valid = iv_r;
    assign bus.last        = last_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.res_valid   = dl[PIPE_LAT-1][IDX_W];
    assign bus.res_idx     = dl[PIPE_LAT-1][IDX_W-1:0];
endmodule
